// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
//   XLEN_DEF / AW_DEF : default data width and address width
//   ZERO_REG          : index of the hardwired-zero register
//   cnt_w()           : width of the busy counter for a given address width
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int ZERO_REG = 0;

  // The counter has to hold up to 2^AW - 1, so AW+1 bits always suffice.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard.
// Holds one pending bit per architectural register and a registered count
// of how many of them are set.
//   clk, rst_n     : clock, asynchronous active-low reset
//   set_i/set_addr_i : decode issues a writer of set_addr_i
//   clr_i/clr_addr_i : write-back retires a writer of clr_addr_i
//   flush_i        : drop every pending bit (and any same-cycle set)
//   busy_o         : current busy vector, bit 0 always 0
//   busy_cnt_o     : number of set bits in busy_o
module rf_busy_table
  import rf_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_i,
  input  logic [AW-1:0]          set_addr_i,
  input  logic                   clr_i,
  input  logic [AW-1:0]          clr_addr_i,
  input  logic                   flush_i,
  output logic [(2**AW)-1:0]     busy_o,
  output logic [cnt_w(AW)-1:0]   busy_cnt_o
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = cnt_w(AW);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Priority: flush beats everything; otherwise set beats clear so a new
  // producer issued in the retire cycle of the old one stays tracked.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (clr_i && clr_addr_i != AW'(ZERO_REG)) busy_d[clr_addr_i] = 1'b0;
      if (set_i && set_addr_i != AW'(ZERO_REG)) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Counting the next state keeps the registered count in step with busy_q.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/rf_scoreboard_file.sv
// Register file with busy scoreboard for the pipelined core.
// 2^AW registers of XLEN bits, register 0 reads as zero.
//   clk, rst_n        : clock, asynchronous active-low reset
//   we/waddr/wdata    : write-back port (synchronous)
//   raddr/rdata/rbusy : NRD combinational read ports, port k at slice k
//   issue_valid/issue_rd : decode marks issue_rd pending
//   issue_conflict    : issue_rd already pending and not retiring now (WAW)
//   flush             : clear all pending flags
//   busy_cnt          : registered number of pending registers
module rf_scoreboard_file
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [XLEN-1:0]        wdata,
  input  logic [NRD*AW-1:0]      raddr,
  output logic [NRD*XLEN-1:0]    rdata,
  output logic [NRD-1:0]         rbusy,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   issue_conflict,
  input  logic                   flush,
  output logic [cnt_w(AW)-1:0]   busy_cnt
);

  localparam int DEPTH = 2 ** AW;

  logic [XLEN-1:0]  rf_q [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_en;

  assign wr_en = we && (waddr != AW'(ZERO_REG));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[waddr] <= wdata;
    end
  end

  rf_busy_table #(
    .AW (AW)
  ) u_busy (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (issue_valid),
    .set_addr_i (issue_rd),
    .clr_i      (we),
    .clr_addr_i (waddr),
    .flush_i    (flush),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt)
  );

  // A bypassed read sees the producer's data this cycle, so it is no longer
  // waiting on that register.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr[k*AW +: AW];
    assign hit = (BYPASS != 0) && wr_en && (waddr == ra);
    assign rdata[k*XLEN +: XLEN] = hit ? wdata : rf_q[ra];
    assign rbusy[k] = busy[ra] && !hit;
  end

  // Same-cycle retire of issue_rd makes the new issue a clean handover.
  assign issue_conflict = issue_valid && (issue_rd != AW'(ZERO_REG)) &&
                          busy[issue_rd] && !(we && waddr == issue_rd);

endmodule

// File: tb/tb_rf_scoreboard_file.sv
module tb_rf_scoreboard_file;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int DEPTH = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata, rdata_nb;
  logic [NRD-1:0]      rbusy, rbusy_nb;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_conflict, issue_conflict_nb;
  logic                flush;
  logic [AW:0]         busy_cnt, busy_cnt_nb;

  rf_scoreboard_file #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_conflict(issue_conflict), .flush(flush), .busy_cnt(busy_cnt)
  );

  rf_scoreboard_file #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_conflict(issue_conflict_nb), .flush(flush), .busy_cnt(busy_cnt_nb)
  );

  always #5 clk = ~clk;

  // Reference model: architectural contents and the set of pending registers.
  logic [XLEN-1:0] m_rf   [DEPTH];
  bit              m_busy [DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 0;
    end
  endtask

  task automatic idle();
    we = 0; waddr = '0; wdata = '0; raddr = '0;
    issue_valid = 0; issue_rd = '0; flush = 0;
  endtask

  // Compare every output against what the model says for the current inputs.
  task automatic check_outputs();
    logic [AW-1:0] ra;
    bit hit;
    bit exp_conf;
    for (int k = 0; k < NRD; k++) begin
      ra  = raddr[k*AW +: AW];
      hit = we && (waddr != 0) && (waddr == ra);
      chk($sformatf("rdata%0d x%0d", k, ra), rdata[k*XLEN +: XLEN], hit ? wdata : m_rf[ra]);
      chk($sformatf("rbusy%0d x%0d", k, ra), 32'(rbusy[k]), 32'(m_busy[ra] && !hit));
      chk($sformatf("nb_rdata%0d x%0d", k, ra), rdata_nb[k*XLEN +: XLEN], m_rf[ra]);
      chk($sformatf("nb_rbusy%0d x%0d", k, ra), 32'(rbusy_nb[k]), 32'(m_busy[ra]));
    end
    exp_conf = issue_valid && (issue_rd != 0) && m_busy[issue_rd] && !(we && waddr == issue_rd);
    chk("issue_conflict", 32'(issue_conflict), 32'(exp_conf));
    chk("busy_cnt", 32'(busy_cnt), 32'(m_count()));
    chk("nb_busy_cnt", 32'(busy_cnt_nb), 32'(m_count()));
  endtask

  // Check, clock once, apply the spec's update rules to the model.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    if (we && waddr != 0) m_rf[waddr] = wdata;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end else begin
      if (we && waddr != 0) m_busy[waddr] = 0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    @(negedge clk);
  endtask

  function automatic logic [NRD*AW-1:0] rd2(input int a0, input int a1);
    return {AW'(a1), AW'(a0)};
  endfunction

  initial begin
    rst_n = 0;
    idle();
    m_reset();
    repeat (3) @(negedge clk);
    raddr = rd2(5, 31);
    #1;
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rdata1", rdata[63:32], 32'h0);
    chk("rst_rbusy", 32'(rbusy), 32'h0);
    chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1;
    cycle();

    // Write x5, then read it back while writing x0.
    idle(); we = 1; waddr = 5; wdata = 32'hDEADBEEF; cycle();
    idle(); we = 1; waddr = 0; wdata = 32'h12345678; raddr = rd2(5, 0);
    #1;
    chk("x5_readback", rdata[31:0], 32'hDEADBEEF);
    chk("x0_bypass_blocked", rdata[63:32], 32'h0);
    cycle();
    idle(); raddr = rd2(0, 5);
    #1;
    chk("x0_after_write", rdata[31:0], 32'h0);
    cycle();

    // Same-cycle bypass vs. array-only read.
    idle(); we = 1; waddr = 7; wdata = 32'hA5A5A5A5; raddr = rd2(7, 7);
    #1;
    chk("bypass_rdata0", rdata[31:0], 32'hA5A5A5A5);
    chk("nobypass_rdata0", rdata_nb[31:0], 32'h0);
    cycle();

    // Issue, WAW conflict, retire-and-reissue.
    idle(); issue_valid = 1; issue_rd = 3; cycle();
    idle(); raddr = rd2(3, 0);
    #1;
    chk("x3_busy", 32'(rbusy[0]), 32'h1);
    chk("cnt_after_issue", 32'(busy_cnt), 32'h1);
    issue_valid = 1; issue_rd = 3;
    #1;
    chk("waw_conflict", 32'(issue_conflict), 32'h1);
    cycle();
    idle(); we = 1; waddr = 3; wdata = 32'h33; issue_valid = 1; issue_rd = 3; raddr = rd2(3, 0);
    #1;
    chk("retire_no_conflict", 32'(issue_conflict), 32'h0);
    cycle();
    idle(); raddr = rd2(3, 0);
    #1;
    chk("x3_still_busy", 32'(rbusy[0]), 32'h1);
    chk("cnt_reissue", 32'(busy_cnt), 32'h1);
    chk("x3_data", rdata[31:0], 32'h33);
    cycle();

    // Fill, then flush with a dropped issue.
    idle(); flush = 1; cycle();
    idle(); issue_valid = 1; issue_rd = 1; cycle();
    #1; chk("cnt_1", 32'(busy_cnt), 32'd1);
    idle(); issue_valid = 1; issue_rd = 2; cycle();
    #1; chk("cnt_2", 32'(busy_cnt), 32'd2);
    idle(); issue_valid = 1; issue_rd = 4; cycle();
    #1; chk("cnt_3", 32'(busy_cnt), 32'd3);
    idle(); flush = 1; issue_valid = 1; issue_rd = 9; cycle();
    idle(); raddr = rd2(9, 1);
    #1;
    chk("cnt_flush", 32'(busy_cnt), 32'd0);
    chk("x9_not_busy", 32'(rbusy[0]), 32'h0);
    cycle();

    // Asynchronous reset mid-cycle.
    idle(); issue_valid = 1; issue_rd = 10; cycle();
    idle(); issue_valid = 1; issue_rd = 11; cycle();
    idle(); raddr = rd2(5, 3);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_cnt", 32'(busy_cnt), 32'h0);
    chk("async_rst_rdata0", rdata[31:0], 32'h0);
    chk("async_rst_rdata1", rdata[63:32], 32'h0);
    chk("async_rst_rbusy", 32'(rbusy), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    cycle();

    // Random traffic; reads often aimed at the write/issue target.
    for (int n = 0; n < 400; n++) begin
      idle();
      we          = ($urandom_range(0, 1) == 1);
      waddr       = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(0, 7));
      wdata       = $urandom;
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd    = ($urandom_range(0, 1) == 1) ? waddr : AW'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 2))
          0:       raddr[k*AW +: AW] = waddr;
          1:       raddr[k*AW +: AW] = issue_rd;
          default: raddr[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        endcase
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard_file.md
Name: rf_scoreboard_file

Overview:
Parametrised register file for the pipelined core: 2^AW registers of XLEN bits, NRD asynchronous read ports, one synchronous write port and optional write-to-read bypass.
- Adds a per-register busy scoreboard: decode marks a destination pending, write-back clears it, flush clears all.
- Hazard logic reads busy flags and a registered pending count instead of comparing pipeline addresses.
- Sits between decode (read, issue) and write-back (write).

Parameters:
XLEN, 32, register data width
AW, 5, register address width; depth = 2^AW
NRD, 2, number of read ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns array contents only

Ports:
clk  in  1  core clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
we  in  1  write-back enable
waddr  in  AW  write-back destination
wdata  in  XLEN  write-back data
raddr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rdata  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rbusy  out  NRD  port k source register still pending
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  AW  destination of issued instruction
issue_conflict  out  1  issue_rd already busy and not being cleared this cycle (WAW)
flush  in  1  clear all busy flags (pipeline flush)
busy_cnt  out  AW+1  registered number of busy registers

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy = 0, busy_cnt = 0. rdata follows the array, so it reads 0 while reset is held. Reset asserted mid-operation discards pending state immediately.
- Register 0 is hardwired zero:
  - reads of address 0 return 0 and rbusy = 0;
  - writes to 0 are ignored;
  - issue to 0 sets nothing and never raises issue_conflict;
  - busy[0] is constant 0.
- Write: at posedge, if we && waddr != 0 then rf[waddr] <= wdata and busy[waddr] is cleared (subject to the issue rule below). Single-cycle latency; the value is visible through the array from the next cycle.
- Read (combinational, every port independent):
  - hit_k = BYPASS && we && waddr != 0 && waddr == raddr_k;
  - rdata_k = hit_k ? wdata : rf[raddr_k];
  - rbusy_k = busy[raddr_k] && !hit_k.
  - With BYPASS = 0: rdata_k = rf[raddr_k] and rbusy_k = busy[raddr_k].
- Issue: at posedge, if issue_valid && issue_rd != 0 && !flush then busy[issue_rd] <= 1.
- Simultaneous write-back and issue to the same register: set wins, busy stays 1 (new producer). The data write still occurs.
- issue_conflict = issue_valid && issue_rd != 0 && busy[issue_rd] && !(we && waddr == issue_rd). Informational only: the block still sets busy, and stalling is decode's decision.
- Flush: at posedge all busy <= 0. An issue in the same cycle is dropped. A write in the same cycle still updates the array.
- busy_cnt: registered popcount of next-state busy, so it always equals the number of set busy bits in the same cycle. Range 0..2^AW-1, width AW+1, never wraps.
- Writes to a non-busy register are legal (e.g. after flush); the array updates and busy stays 0.

Decomposition:
- Package rf_pkg: default XLEN and AW, ZERO_REG = 0, a function for the popcount width.
- Sub-module rf_busy_table:
  - owns the busy vector, the set/clear/flush priority and busy_cnt;
  - exports the busy vector to the top;
  - the top holds the data array, read muxes and bypass.

Test Plan:
- Reset held, then released; read ports 0/1 at x5, x31 -> rdata = 0, rbusy = 0, busy_cnt = 0.
- Write x5 = 0xDEADBEEF, then read x5 the next cycle. In the same cycle, write x0 = 0x12345678 -> x5 reads 0xDEADBEEF; x0 reads 0.
- BYPASS = 1: we with waddr = 7, wdata = 0xA5A5A5A5 while raddr0 = 7 in the same cycle -> rdata0 = 0xA5A5A5A5 combinationally. BYPASS = 0 build -> rdata0 = old value (0).
- Issue x3 -> next cycle rbusy for x3 = 1, busy_cnt = 1. Issue x3 again -> issue_conflict = 1. Write-back x3 together with issue x3 -> busy stays 1, busy_cnt = 1, data written.
- Issue x1, x2, x4 on consecutive cycles, then flush together with issue x9 -> busy_cnt 1, 2, 3, then 0; x9 not busy.
- Issue x10 and x11, then assert rst_n low asynchronously between clock edges -> busy_cnt = 0 and all rdata = 0 immediately, without waiting for a clock edge.
